// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time configuration sequencer: freezes and programs every core tile over the
// config bus, then unfreezes them all, keeping exactly one write outstanding.
module bp_cfg_boot_sequencer #(
  parameter int num_core_p       = 2,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int timeout_p        = 64,
  localparam int core_w_lp       = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_w_lp-1:0]        cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ack_v_i,
  output logic                        done_o,
  output logic                        error_o
);

  // Handshake: a request transfers on any cycle where cfg_v_o & cfg_ready_i; while
  // cfg_v_o waits for ready the payload is held stable. Every transfer is answered by
  // exactly one cfg_ack_v_i pulse, and no new request is raised before that pulse.

  localparam int timer_w_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [timer_w_lp-1:0] timer_max_lp =
    (timeout_p > 0) ? timer_w_lp'(timeout_p - 1) : '0;
  localparam logic [core_w_lp-1:0] last_core_lp = core_w_lp'(num_core_p - 1);

  typedef enum logic [2:0] {
    IDLE_S, SEND_S, WAIT_ACK_S, DONE_S, ERROR_S
  } state_e;

  state_e                 state_q, state_d;
  logic [core_w_lp-1:0]   core_q, core_d;
  logic [1:0]             reg_q, reg_d;
  logic                   pass_q, pass_d;
  logic                   last_q, last_d;
  logic [timer_w_lp-1:0]  timer_q, timer_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE_S;
      core_q  <= '0;
      reg_q   <= '0;
      pass_q  <= 1'b0;
      last_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      reg_q   <= reg_d;
      pass_q  <= pass_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    core_d     = core_q;
    reg_d      = reg_q;
    pass_d     = pass_q;
    last_d     = last_q;
    timer_d    = timer_q;
    cfg_v_o    = 1'b0;
    cfg_core_o = '0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    done_o     = (state_q == DONE_S);
    error_o    = (state_q == ERROR_S);

    case (state_q)
      IDLE_S: state_d = SEND_S;

      SEND_S: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = core_q;
        if (pass_q) begin
          cfg_addr_o = cfg_addr_width_p'(1);
          cfg_data_o = '0;
        end else begin
          // Registers 0x1..0x4 map directly onto reg_cnt 0..3; only CORE_ID carries the index.
          cfg_addr_o = cfg_addr_width_p'({1'b0, reg_q} + 3'd1);
          cfg_data_o = (reg_q == 2'd1) ? cfg_data_width_p'(core_q) : cfg_data_width_p'(1);
        end

        if (cfg_ready_i) begin
          timer_d = '0;
          state_d = WAIT_ACK_S;
          if (!pass_q) begin
            reg_d = reg_q + 2'd1;
            if (reg_q == 2'd3) begin
              if (core_q == last_core_lp) begin
                core_d = '0;
                pass_d = 1'b1;
              end else begin
                core_d = core_q + 1'b1;
              end
            end
          end else if (core_q == last_core_lp) begin
            core_d = '0;
            last_d = 1'b1;
          end else begin
            core_d = core_q + 1'b1;
          end
        end
      end

      WAIT_ACK_S: begin
        timer_d = timer_q + 1'b1;
        if (cfg_ack_v_i) begin
          state_d = last_q ? DONE_S : SEND_S;
        end else if ((timeout_p != 0) && (timer_q == timer_max_lp)) begin
          state_d = ERROR_S;
        end
      end

      DONE_S:  state_d = DONE_S;
      ERROR_S: state_d = ERROR_S;
      default: state_d = IDLE_S;
    endcase
  end

  // Acks outside WAIT_ACK are dropped by the FSM; flag them without stopping simulation.
  a_ack_only_when_waiting: assert property (
    @(posedge clk_i) disable iff (reset_i) cfg_ack_v_i |-> (state_q == WAIT_ACK_S)
  ) else $warning("config ack received while not waiting for one");

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Bench for bp_cfg_boot_sequencer: a two-core instance with a short timeout and a
// single-core instance without timeout, checked against a write-list reference model.
module tb_bp_cfg_boot_sequencer;

  localparam int N   = 2;
  localparam int TMO = 4;

  logic        clk;
  logic        reset_i, cfg_ready_i, cfg_ack_v_i;
  logic        cfg_v_o, done_o, error_o;
  logic [0:0]  cfg_core_o;
  logic [15:0] cfg_addr_o;
  logic [31:0] cfg_data_o;

  logic        reset2, ready2, ack2;
  logic        v2, done2, err2;
  logic [0:0]  core2;
  logic [15:0] addr2;
  logic [31:0] data2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int start_cyc;
  int extra;
  logic [55:0] exp_q[$];

  bp_cfg_boot_sequencer #(.num_core_p(N), .timeout_p(TMO)) dut (
    .clk_i(clk), .reset_i(reset_i), .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i),
    .cfg_core_o(cfg_core_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
    .cfg_ack_v_i(cfg_ack_v_i), .done_o(done_o), .error_o(error_o)
  );

  bp_cfg_boot_sequencer #(.num_core_p(1), .timeout_p(0)) dut1 (
    .clk_i(clk), .reset_i(reset2), .cfg_v_o(v2), .cfg_ready_i(ready2),
    .cfg_core_o(core2), .cfg_addr_o(addr2), .cfg_data_o(data2),
    .cfg_ack_v_i(ack2), .done_o(done2), .error_o(err2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the ordered list of writes for n cores.
  task automatic build_exp(input int n);
    exp_q.delete();
    for (int c = 0; c < n; c++) begin
      exp_q.push_back({8'(c), 16'h0001, 32'd1});
      exp_q.push_back({8'(c), 16'h0002, 32'(c)});
      exp_q.push_back({8'(c), 16'h0003, 32'd1});
      exp_q.push_back({8'(c), 16'h0004, 32'd1});
    end
    for (int c = 0; c < n; c++) exp_q.push_back({8'(c), 16'h0001, 32'd0});
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    cyc++;
    cfg_ready_i = 1'b0;
    cfg_ack_v_i = 1'b0;
    ready2      = 1'b0;
    ack2        = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_v"},    32'(cfg_v_o), 32'd0);
    check({tag, "_core"}, 32'(cfg_core_o), 32'd0);
    check({tag, "_addr"}, 32'(cfg_addr_o), 32'd0);
    check({tag, "_data"}, cfg_data_o, 32'd0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    check_quiet("rst");
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(error_o), 32'd0);
    reset_i   = 1'b0;
    start_cyc = cyc;
    extra     = 0;
  endtask

  task automatic do_req(input int stall);
    logic [55:0] it;
    if (exp_q.size() == 0) begin
      check("exp_empty", 32'd1, 32'd0);
      return;
    end
    it = exp_q.pop_front();
    for (int s = 0; s <= stall; s++) begin
      tick();
      check("req_v",    32'(cfg_v_o), 32'd1);
      check("req_core", 32'(cfg_core_o), 32'(it[55:48]));
      check("req_addr", 32'(cfg_addr_o), 32'(it[47:32]));
      check("req_data", cfg_data_o, it[31:0]);
      check("req_done", 32'(done_o), 32'd0);
      if (s == stall) cfg_ready_i = 1'b1;
    end
    extra += stall;
  endtask

  task automatic do_ack(input int delay, output bit timed_out);
    timed_out = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      tick();
      check_quiet("wait");
      check("wait_err", 32'(error_o), 32'd0);
      if (k == delay) begin
        cfg_ack_v_i = 1'b1;
        extra += delay;
        return;
      end
    end
    tick();
    check("tmo_err", 32'(error_o), 32'd1);
    check("tmo_v", 32'(cfg_v_o), 32'd0);
    timed_out = 1'b1;
  endtask

  task automatic run_full(input bit rnd, input int stall_idx, input int tie_idx);
    bit to;
    int stall, delay;
    build_exp(N);
    for (int i = 0; i < 5 * N; i++) begin
      stall = rnd ? int'($urandom_range(0, 3)) : 0;
      delay = rnd ? int'($urandom_range(0, TMO - 1)) : 0;
      if (i == stall_idx) stall = 5;
      if (i == tie_idx) delay = TMO - 1;
      do_req(stall);
      do_ack(delay, to);
      if (to) begin
        check("unexpected_timeout", 32'd1, 32'd0);
        return;
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done_o) break;
    end
    check("done", 32'(done_o), 32'd1);
    check("done_lat", 32'(cyc - start_cyc), 32'(1 + 10 * N + extra));
    check("exp_left", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("done_sticky", 32'(done_o), 32'd1);
      check_quiet("post_done");
    end
  endtask

  initial begin
    bit to;
    int d;
    logic [55:0] it;
    reset_i = 1'b1; cfg_ready_i = 1'b0; cfg_ack_v_i = 1'b0;
    reset2  = 1'b1; ready2 = 1'b0; ack2 = 1'b0;

    // Back-to-back ready and ack: table order, done after 1+10N cycles.
    do_reset();
    run_full(1'b0, -1, -1);

    // Ready withheld for five cycles on the third write.
    do_reset();
    run_full(1'b0, 2, -1);

    // Ack arriving on the final timeout cycle still counts.
    do_reset();
    run_full(1'b0, -1, 1);

    // Randomized ready stalls and ack delays within the timeout window.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      run_full(1'b1, -1, -1);
    end

    // Ack withheld for the second write: sticky error, bus stays quiet.
    do_reset();
    build_exp(N);
    do_req(0);
    do_ack(0, to);
    do_req(0);
    do_ack(TMO, to);
    check("tmo_seen", 32'(to), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("err_sticky", 32'(error_o), 32'd1);
      check("err_done", 32'(done_o), 32'd0);
      check_quiet("post_err");
    end

    // Reset in pass 2 with an ack in flight, then a complete rerun.
    do_reset();
    build_exp(N);
    for (int i = 0; i < 4 * N; i++) begin
      do_req(int'($urandom_range(0, 1)));
      do_ack(0, to);
    end
    do_req(0);
    tick();
    check("p2_wait_v", 32'(cfg_v_o), 32'd0);
    cfg_ack_v_i = 1'b1;
    do_reset();
    run_full(1'b0, -1, -1);

    // Single-core instance, no timeout, random ack delays.
    tick();
    tick();
    check("c1_rst_v", 32'(v2), 32'd0);
    check("c1_rst_done", 32'(done2), 32'd0);
    reset2 = 1'b0;
    start_cyc = cyc;
    extra = 0;
    build_exp(1);
    for (int i = 0; i < 5; i++) begin
      it = exp_q.pop_front();
      tick();
      check("c1_v",    32'(v2), 32'd1);
      check("c1_core", 32'(core2), 32'(it[55:48]));
      check("c1_addr", 32'(addr2), 32'(it[47:32]));
      check("c1_data", data2, it[31:0]);
      ready2 = 1'b1;
      d = int'($urandom_range(0, 7));
      extra += d;
      for (int k = 0; k <= d; k++) begin
        tick();
        check("c1_wait_v", 32'(v2), 32'd0);
        check("c1_wait_err", 32'(err2), 32'd0);
        if (k == d) ack2 = 1'b1;
      end
    end
    tick();
    check("c1_done", 32'(done2), 32'd1);
    check("c1_done_lat", 32'(cyc - start_cyc), 32'(11 + extra));
    check("c1_err", 32'(err2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
